// File: rtl/control_pkg.sv
// control_pkg: opcode constants, ALU operation encodings and the control-word layout
package control_pkg;

  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_SUB  = 6'h01;
  localparam logic [5:0] OP_AND  = 6'h02;
  localparam logic [5:0] OP_OR   = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  // Field order matches the output tuple: regDst, jump, branch, memToReg, aluOp, memWrite, aluSrc, regWrite
  typedef struct packed {
    logic       reg_dst;
    logic       jump;
    logic       branch;
    logic       mem_to_reg;
    logic [1:0] alu_op;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/control_decode.sv
// control_decode: combinational opcode-to-control-word decode
module control_decode
  import control_pkg::*;
(
  input  logic [5:0] opcode_i,
  output ctrl_t      ctrl_o
);

  // Unknown opcodes fall through to the all-zero NOP word
  always_comb begin
    ctrl_o = CTRL_NOP;
    case (opcode_i)
      OP_ADD:  ctrl_o = '{reg_dst: 1'b1, alu_op: ALU_ADD, reg_write: 1'b1, default: 1'b0};
      OP_SUB:  ctrl_o = '{reg_dst: 1'b1, alu_op: ALU_SUB, reg_write: 1'b1, default: 1'b0};
      OP_AND:  ctrl_o = '{reg_dst: 1'b1, alu_op: ALU_AND, reg_write: 1'b1, default: 1'b0};
      OP_OR:   ctrl_o = '{reg_dst: 1'b1, alu_op: ALU_OR,  reg_write: 1'b1, default: 1'b0};
      OP_ADDI: ctrl_o = '{alu_src: 1'b1, reg_write: 1'b1, alu_op: ALU_ADD, default: 1'b0};
      OP_LW:   ctrl_o = '{mem_to_reg: 1'b1, alu_src: 1'b1, reg_write: 1'b1, alu_op: ALU_ADD, default: 1'b0};
      OP_SW:   ctrl_o = '{mem_write: 1'b1, alu_src: 1'b1, alu_op: ALU_ADD, default: 1'b0};
      OP_BEQ:  ctrl_o = '{branch: 1'b1, alu_op: ALU_SUB, default: 1'b0};
      OP_J:    ctrl_o = '{jump: 1'b1, alu_op: ALU_ADD, default: 1'b0};
      default: ctrl_o = CTRL_NOP;
    endcase
  end

endmodule

// File: rtl/control.sv
// control: registered main control unit; decodes the opcode and holds the control word for one cycle
module control
  import control_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_instrCode,
  output logic        o_regDst,
  output logic        o_jump,
  output logic        o_branch,
  output logic        o_memToReg,
  output logic [1:0]  o_aluOp,
  output logic        o_memWrite,
  output logic        o_aluSrc,
  output logic        o_regWrite
);

  ctrl_t ctrl_d, ctrl_q;
  logic  unused_fields;

  assign unused_fields = ^i_instrCode[9:0];

  control_decode u_decode (
    .opcode_i (i_instrCode[15:10]),
    .ctrl_o   (ctrl_d)
  );

  // Output register; async reset clears the word so no stale decode survives reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) ctrl_q <= CTRL_NOP;
    else       ctrl_q <= ctrl_d;
  end

  assign o_regDst   = ctrl_q.reg_dst;
  assign o_jump     = ctrl_q.jump;
  assign o_branch   = ctrl_q.branch;
  assign o_memToReg = ctrl_q.mem_to_reg;
  assign o_aluOp    = ctrl_q.alu_op;
  assign o_memWrite = ctrl_q.mem_write;
  assign o_aluSrc   = ctrl_q.alu_src;
  assign o_regWrite = ctrl_q.reg_write;

endmodule

// File: tb/tb_control.sv
// tb_control: directed checks of the registered control unit
`timescale 1ns/1ns
module tb_control;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic        reg_dst, jump, branch, mem_to_reg, mem_write, alu_src, reg_write;
  logic [1:0]  alu_op;
  int          total = 0;
  int          bad = 0;

  control dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_instrCode (instr),
    .o_regDst    (reg_dst),
    .o_jump      (jump),
    .o_branch    (branch),
    .o_memToReg  (mem_to_reg),
    .o_aluOp     (alu_op),
    .o_memWrite  (mem_write),
    .o_aluSrc    (alu_src),
    .o_regWrite  (reg_write)
  );

  always #10 clk = ~clk;

  wire [8:0] outs = {reg_dst, jump, branch, mem_to_reg, alu_op, mem_write, alu_src, reg_write};

  localparam logic [8:0] E_ADD  = 9'b1_0_0_0_00_0_0_1;
  localparam logic [8:0] E_SUB  = 9'b1_0_0_0_01_0_0_1;
  localparam logic [8:0] E_AND  = 9'b1_0_0_0_10_0_0_1;
  localparam logic [8:0] E_OR   = 9'b1_0_0_0_11_0_0_1;
  localparam logic [8:0] E_ADDI = 9'b0_0_0_0_00_0_1_1;
  localparam logic [8:0] E_LW   = 9'b0_0_0_1_00_0_1_1;
  localparam logic [8:0] E_SW   = 9'b0_0_0_0_00_1_1_0;
  localparam logic [8:0] E_BEQ  = 9'b0_0_1_0_01_0_0_0;
  localparam logic [8:0] E_J    = 9'b0_1_0_0_00_0_0_0;

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct { string name; logic [5:0] op; logic [8:0] exp; } vec_t;
  vec_t sweep[9];

  initial begin
    sweep[0] = '{"beq",  6'h04, E_BEQ};
    sweep[1] = '{"j",    6'h05, E_J};
    sweep[2] = '{"sw",   6'h2B, E_SW};
    sweep[3] = '{"lw",   6'h23, E_LW};
    sweep[4] = '{"add",  6'h00, E_ADD};
    sweep[5] = '{"sub",  6'h01, E_SUB};
    sweep[6] = '{"or",   6'h03, E_OR};
    sweep[7] = '{"and",  6'h02, E_AND};
    sweep[8] = '{"addi", 6'h08, E_ADDI};

    instr = 16'hFFFF;
    #1 rst = 1'b1;
    #1 check("reset_async", outs, 9'h000);
    #1 rst = 1'b0;
    tick();
    check("illegal_3f", outs, 9'h000);

    foreach (sweep[i]) begin
      instr = {sweep[i].op, 10'b0};
      check({sweep[i].name, "_pre"}, outs, i == 0 ? 9'h000 : sweep[i-1].exp);
      tick();
      check(sweep[i].name, outs, sweep[i].exp);
    end

    instr = {6'h23, 10'h3FF};
    tick();
    check("lw_fields", outs, E_LW);
    instr = {6'h3F, 10'h000};
    tick();
    check("nop_after_lw", outs, 9'h000);
    instr = {6'h2B, 10'h155};
    tick();
    check("sw_fields", outs, E_SW);

    instr = 16'h0000;
    tick();
    check("lat_add", outs, E_ADD);
    #17 instr = {6'h2B, 10'b0};
    #1 check("lat_hold_add", outs, E_ADD);
    tick();
    check("lat_sw", outs, E_SW);

    instr = {6'h23, 10'b0};
    tick();
    check("mid_lw", outs, E_LW);
    #3 rst = 1'b1;
    #1 check("mid_rst_async", outs, 9'h000);
    #2 rst = 1'b0;
    #1 check("mid_rst_released", outs, 9'h000);
    tick();
    check("mid_lw_return", outs, E_LW);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
